// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM, and holds the
// decode instruction stable across stalls. A pending redirect keeps branch targets alive while the PC is frozen.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'hBFBF_FFFC,
    parameter int          STALL_W    = 6,
    parameter int          BR_W       = 33,
    parameter int          IF_TO_ID_W = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic [BR_W-1:0]       br_bus,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_wen,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic [31:0]           inst_sram_rdata,
    output logic [IF_TO_ID_W-1:0] if_to_id_bus,
    output logic [31:0]           id_inst
);

    logic        br_e;
    logic [31:0] br_addr;
    logic        pc_stop;
    logic        id_stop;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        ce_reg;
    logic        br_pend_reg;
    logic [31:0] br_pend_addr_reg;
    logic        hold_valid_reg;
    logic [31:0] hold_inst_reg;

    assign br_e    = br_bus[BR_W-1];
    assign br_addr = br_bus[31:0];
    assign pc_stop = stall[0];
    assign id_stop = stall[2];

    // Stage bits not consumed by fetch are folded away here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:3], stall[1]};

    // A live branch beats a parked one; the parked one beats sequential fetch.
    always_comb begin
        pc_next = pc_reg + 32'd4;
        if (br_e) begin
            pc_next = br_addr;
        end else if (br_pend_reg) begin
            pc_next = br_pend_addr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg           <= RESET_PC;
            ce_reg           <= 1'b0;
            br_pend_reg      <= 1'b0;
            br_pend_addr_reg <= 32'd0;
        end else if (!pc_stop) begin
            pc_reg      <= pc_next;
            ce_reg      <= 1'b1;
            br_pend_reg <= 1'b0;
        end else if (br_e) begin
            br_pend_reg      <= 1'b1;
            br_pend_addr_reg <= br_addr;
        end
    end

    // Capture the word decode sees on the first stalled edge and keep it until release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_reg <= 1'b0;
            hold_inst_reg  <= 32'd0;
        end else if (id_stop) begin
            if (!hold_valid_reg) begin
                hold_valid_reg <= 1'b1;
                hold_inst_reg  <= inst_sram_rdata;
            end
        end else begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign inst_sram_en    = ce_reg;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'd0;

    // The PC field reads as zero until the first real fetch so the bus is all-zero out of reset.
    assign if_to_id_bus = {ce_reg, (ce_reg ? pc_reg : 32'd0)};
    assign id_inst      = hold_valid_reg ? hold_inst_reg : inst_sram_rdata;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: expected fetch addresses are queued as stimulus
// is driven and popped after each clock edge.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] id_inst;

    int pass_count;
    int total_count;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .if_to_id_bus   (if_to_id_bus),
        .id_inst        (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and compare the fetch address against the scoreboard head.
    task automatic edge_and_check_addr(input string name);
        @(posedge clk);
        #1;
        exp_addr = exp_q.pop_front();
        total_count++;
        if (inst_sram_addr !== exp_addr || inst_sram_en !== 1'b1 || if_to_id_bus !== {1'b1, exp_addr}) begin
            $display("FAIL %s: addr=%h en=%b bus=%h required addr=%h en=1", name, inst_sram_addr, inst_sram_en, if_to_id_bus, exp_addr);
        end else begin
            pass_count++;
            $display("ok   %s: addr=%h", name, inst_sram_addr);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        stall = 6'b0;
        br_bus = 33'b0;
        inst_sram_rdata = 32'h1111_2222;
        repeat (2) @(posedge clk);
        #1;
        total_count++;
        if (inst_sram_en !== 1'b0 || if_to_id_bus !== 33'b0 || inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
            $display("FAIL reset_outputs: en=%b bus=%h wen=%b wdata=%h required 0/0/0/0", inst_sram_en, if_to_id_bus, inst_sram_wen, inst_sram_wdata);
        end else begin
            pass_count++;
            $display("ok   reset_outputs");
        end
        total_count++;
        if (id_inst !== 32'h1111_2222) begin
            $display("FAIL reset_id_inst: got=%h required=%h", id_inst, 32'h1111_2222);
        end else begin
            pass_count++;
            $display("ok   reset_id_inst: %h", id_inst);
        end
    endtask

    task automatic test_sequential;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hBFC0_0000 + 32'(i * 4));
            edge_and_check_addr("seq_fetch");
        end
    endtask

    task automatic test_branch;
        br_bus = {1'b1, 32'hBFC0_0100};
        exp_q.push_back(32'hBFC0_0100);
        edge_and_check_addr("branch_target");
        br_bus = 33'b0;
        exp_q.push_back(32'hBFC0_0104);
        edge_and_check_addr("branch_plus4");
    endtask

    task automatic test_stall_hold;
        stall = 6'b000111;
        inst_sram_rdata = 32'h3C01_1234;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hBFC0_0104);
            edge_and_check_addr("stall_pc_frozen");
            inst_sram_rdata = 32'hDEAD_0000 + 32'(i);
            total_count++;
            if (id_inst !== 32'h3C01_1234) begin
                $display("FAIL stall_hold_inst: got=%h required=%h", id_inst, 32'h3C01_1234);
            end else begin
                pass_count++;
                $display("ok   stall_hold_inst: %h", id_inst);
            end
        end
        stall = 6'b0;
        inst_sram_rdata = 32'h2401_0005;
        exp_q.push_back(32'hBFC0_0108);
        edge_and_check_addr("stall_release");
        total_count++;
        if (id_inst !== 32'h2401_0005) begin
            $display("FAIL release_passthrough: got=%h required=%h", id_inst, 32'h2401_0005);
        end else begin
            pass_count++;
            $display("ok   release_passthrough: %h", id_inst);
        end
    endtask

    task automatic test_pending;
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        exp_q.push_back(32'hBFC0_0108);
        edge_and_check_addr("pend_frozen_1");
        br_bus = 33'b0;
        exp_q.push_back(32'hBFC0_0108);
        edge_and_check_addr("pend_frozen_2");
        br_bus = {1'b1, 32'hBFC0_0300};
        exp_q.push_back(32'hBFC0_0108);
        edge_and_check_addr("pend_frozen_3");
        br_bus = 33'b0;
        stall = 6'b0;
        exp_q.push_back(32'hBFC0_0300);
        edge_and_check_addr("pend_last_wins");
        exp_q.push_back(32'hBFC0_0304);
        edge_and_check_addr("pend_cleared");
        // Parked redirect overridden by a live branch on the release edge.
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0400};
        exp_q.push_back(32'hBFC0_0304);
        edge_and_check_addr("pend_frozen_4");
        stall = 6'b0;
        br_bus = {1'b1, 32'hBFC0_0500};
        exp_q.push_back(32'hBFC0_0500);
        edge_and_check_addr("live_beats_pend");
        br_bus = 33'b0;
        exp_q.push_back(32'hBFC0_0504);
        edge_and_check_addr("live_pend_cleared");
    endtask

    task automatic test_wrap;
        br_bus = {1'b1, 32'hFFFF_FFFC};
        exp_q.push_back(32'hFFFF_FFFC);
        edge_and_check_addr("wrap_setup");
        br_bus = 33'b0;
        exp_q.push_back(32'h0000_0000);
        edge_and_check_addr("wrap_zero");
        exp_q.push_back(32'h0000_0004);
        edge_and_check_addr("wrap_plus4");
    endtask

    task automatic test_reset_mid;
        stall = 6'b000101;
        br_bus = {1'b1, 32'hBFC0_0600};
        inst_sram_rdata = 32'hCAFE_0001;
        exp_q.push_back(32'h0000_0004);
        edge_and_check_addr("midrst_frozen");
        br_bus = 33'b0;
        inst_sram_rdata = 32'hCAFE_0002;
        #2;
        rst = 1'b0;
        #1;
        total_count++;
        if (inst_sram_en !== 1'b0 || if_to_id_bus !== 33'b0 || inst_sram_addr !== 32'hBFBF_FFFC) begin
            $display("FAIL midrst_clear: en=%b bus=%h addr=%h required en=0 bus=0 addr=bfbffffc", inst_sram_en, if_to_id_bus, inst_sram_addr);
        end else begin
            pass_count++;
            $display("ok   midrst_clear");
        end
        total_count++;
        if (id_inst !== 32'hCAFE_0002) begin
            $display("FAIL midrst_hold_clear: got=%h required=%h", id_inst, 32'hCAFE_0002);
        end else begin
            pass_count++;
            $display("ok   midrst_hold_clear: %h", id_inst);
        end
        #2;
        rst = 1'b1;
        stall = 6'b0;
        exp_q.push_back(32'hBFC0_0000);
        edge_and_check_addr("midrst_restart");
        exp_q.push_back(32'hBFC0_0004);
        edge_and_check_addr("midrst_no_stale");
    endtask

    initial begin
        pass_count = 0;
        total_count = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_hold();
        test_pending();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
